regfile: RTL

REGFILE -- requirements
Module: regfile

---
 rtl/regfile.sv | 87 ++++++++
 1 files changed

// File: rtl/regfile.sv
// regfile: WIDTH-bit architectural register file with one write port, two
// combinational read ports, write-through bypass and a hardwired zero register
// at the top address (X31).
module regfile #(
    parameter int WIDTH = 64,
    parameter int NREGS = 32
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     RegWrite,
    input  logic [$clog2(NREGS)-1:0] WriteRegister,
    input  logic [WIDTH-1:0]         WriteData,
    input  logic [$clog2(NREGS)-1:0] ReadRegister1,
    input  logic [$clog2(NREGS)-1:0] ReadRegister2,
    output logic [WIDTH-1:0]         ReadData1,
    output logic [WIDTH-1:0]         ReadData2
);

    localparam int ADDR_W = $clog2(NREGS);

    // The highest address is the zero register: never written, always reads 0.
    localparam logic [ADDR_W-1:0] ZERO_REG = ADDR_W'(NREGS - 1);

    // Register contents and their next-state image.
    logic [WIDTH-1:0] regs_q [NREGS];
    logic [WIDTH-1:0] regs_d [NREGS];

    // A write takes effect only outside reset and never at the zero register.
    // The same qualifier gates the read bypass, so a discarded write can
    // never leak onto a read port.
    logic wr_fire;

    // Qualify the write port once; both the storage and the bypass use it.
    always_comb begin
        wr_fire = !reset && RegWrite && (WriteRegister != ZERO_REG);
    end

    // Next-state for the storage: hold, clear on reset, or accept one write.
    always_comb begin
        // NOTE: every always_comb output gets a full default first so no path
        // leaves it unassigned, which would otherwise infer a latch.
        regs_d = regs_q;
        if (reset) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_d[i] = '0;
            end
        end else if (wr_fire) begin
            regs_d[WriteRegister] = WriteData;
        end
    end

    // Storage update on the rising edge; reset is synchronous.
    always_ff @(posedge clk) begin
        // NOTE: sequential state is assigned with <= so every register samples
        // its pre-edge value; = here would create order-dependent races.
        // NOTE: this storage is deliberately reset (all entries clear in one
        // edge), so it maps to flops rather than a RAM macro without reset.
        for (int i = 0; i < NREGS; i++) begin
            regs_q[i] <= regs_d[i];
        end
    end

    // Read port 1: zero register, then bypass of the in-flight write, then storage.
    always_comb begin
        ReadData1 = '0;
        if (ReadRegister1 == ZERO_REG) begin
            ReadData1 = '0;
        end else if (wr_fire && (ReadRegister1 == WriteRegister)) begin
            ReadData1 = WriteData;
        end else begin
            ReadData1 = regs_q[ReadRegister1];
        end
    end

    // Read port 2: same priority as port 1, evaluated independently.
    always_comb begin
        ReadData2 = '0;
        if (ReadRegister2 == ZERO_REG) begin
            ReadData2 = '0;
        end else if (wr_fire && (ReadRegister2 == WriteRegister)) begin
            ReadData2 = WriteData;
        end else begin
            ReadData2 = regs_q[ReadRegister2];
        end
    end

endmodule
